// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit that owns the architectural HI/LO
// registers. The result is computed from the operands present on the accepting
// edge and held in pending registers. It is written to HI/LO on the final busy
// edge, so HI/LO keep their old values for the whole busy window.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0]    MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0]    DIV_LOAD  = CW'(DIV_CYCLES - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pend_hi, pend_lo;
    logic             pend_wr;

    logic             accept;
    logic             md_op;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] div_b;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0] q_s, r_s, q_u, r_u;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             res_wr;

    // ops 0..3 are the multi-cycle ones; op[2] separates them from MTHI/MTLO/no-op
    assign md_op     = ~op[2];
    assign accept    = start & ~busy;
    assign stall_req = busy | (start & md_op);

    // Sign-/zero-extend to 2*WIDTH so the truncated product is exact either way
    assign prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

    // Zero divisor and most-negative / -1 are patched afterwards; feed the
    // divider a harmless 1 so it never sees an undefined or trapping case.
    assign div_zero = (src_b == '0);
    assign div_ovf  = (op == OP_DIV) && (src_a == MOST_NEG) && (src_b == ALL_ONES);
    assign div_b    = (div_zero || div_ovf) ? ONE : src_b;

    // Signed divide truncates toward zero and the remainder follows the dividend
    assign q_s = WIDTH'($signed(src_a) / $signed(div_b));
    assign r_s = WIDTH'($signed(src_a) % $signed(div_b));
    assign q_u = src_a / div_b;
    assign r_u = src_a % div_b;

    // Result selection for the pending registers; divide-by-zero writes nothing
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b0;
        case (op)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_wr = 1'b1;
            end
            OP_DIV: begin
                if (div_ovf) begin
                    res_lo = MOST_NEG;
                    res_hi = '0;
                end else begin
                    res_lo = q_s;
                    res_hi = r_s;
                end
                res_wr = ~div_zero;
            end
            OP_DIVU: begin
                res_lo = q_u;
                res_hi = r_u;
                res_wr = ~div_zero;
            end
            default: ;
        endcase
    end

    // Control FSM: accept in IDLE, count down in RUN, commit HI/LO on exit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (md_op) begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            cnt     <= op[1] ? DIV_LOAD : MULT_LOAD;
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            pend_wr <= res_wr;
                        end else if (op == OP_MTHI) begin
                            hi <= src_a;
                        end else if (op == OP_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        pend_wr <= 1'b0;
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed bench for mdu_unit with the default parameters
// (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10). The bench drives inputs and samples
// outputs 1 ns after each rising edge.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .stall_req(stall_req),
        .hi(hi), .lo(lo)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
        reset = 1'b1;
    endtask

    // Called right after reset release: the start lands in the first post-reset cycle
    task automatic test_mult_signed();
        drive(3'd0, 32'hFFFF_FFFE, 32'd3);
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL mult_stall_T: got %b expected 1", stall_req); end
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_T+%0d: got %b expected 1", k, busy); end
            checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL mult_hold_T+%0d: got hi=%h lo=%h expected hi=0 lo=0", k, hi, lo); end
            checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL mult_stall_T+%0d: got %b expected 1", k, stall_req); end
            cyc();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_T+6: got %b expected 0", busy); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL mult_stall_T+6: got %b expected 0", stall_req); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h expected %h", lo, 32'hFFFF_FFFA); end
    endtask

    task automatic test_multu();
        drive(3'd1, 32'hFFFF_FFFF, 32'd2);
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'h1) begin errors++; $display("FAIL multu_hi: got %h expected %h", hi, 32'h1); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h expected %h", lo, 32'hFFFF_FFFE); end
        drive(3'd0, 32'hFFFF_FFFF, 32'd2);
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mults_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mults_lo: got %h expected %h", lo, 32'hFFFF_FFFE); end
    endtask

    task automatic test_div();
        // -7 / 2 = -3 rem -1
        drive(3'd2, 32'hFFFF_FFF9, 32'd2);
        cyc();
        start = 1'b0;
        repeat (9) cyc();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_busy_T+10: got %b expected 1", busy); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL div_hold_lo_T+10: got %h expected %h", lo, 32'hFFFF_FFFE); end
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_busy_T+11: got %b expected 0", busy); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected %h", lo, 32'hFFFF_FFFD); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
        // most-negative / -1
        drive(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        cyc();
        start = 1'b0;
        repeat (10) cyc();
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected %h", lo, 32'h8000_0000); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected %h", hi, 32'h0); end
        // 7 / -2 = -3 rem 1 (remainder follows dividend)
        drive(3'd2, 32'd7, 32'hFFFF_FFFE);
        cyc();
        start = 1'b0;
        repeat (10) cyc();
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negb_lo: got %h expected %h", lo, 32'hFFFF_FFFD); end
        checks++; if (hi !== 32'h1) begin errors++; $display("FAIL div_negb_hi: got %h expected %h", hi, 32'h1); end
        // DIVU 0xFFFFFFF9 / 2 = 0x7FFFFFFC rem 1
        drive(3'd3, 32'hFFFF_FFF9, 32'd2);
        cyc();
        start = 1'b0;
        repeat (10) cyc();
        checks++; if (lo !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_lo: got %h expected %h", lo, 32'h7FFF_FFFC); end
        checks++; if (hi !== 32'h1) begin errors++; $display("FAIL divu_hi: got %h expected %h", hi, 32'h1); end
        // Divide by zero leaves HI/LO untouched after a full busy window
        drive(3'd4, 32'd5, 32'd0);
        cyc();
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL mthi_5: got %h expected %h", hi, 32'd5); end
        drive(3'd5, 32'd9, 32'd0);
        cyc();
        start = 1'b0;
        checks++; if (lo !== 32'd9) begin errors++; $display("FAIL mtlo_9: got %h expected %h", lo, 32'd9); end
        drive(3'd3, 32'd7, 32'd0);
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divz_busy_T+%0d: got %b expected 1", k, busy); end
            cyc();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divz_busy_T+11: got %b expected 0", busy); end
        checks++; if (hi !== 32'd5 || lo !== 32'd9) begin errors++; $display("FAIL divz_hilo: got hi=%h lo=%h expected hi=5 lo=9", hi, lo); end
    endtask

    task automatic test_interlock();
        // 100 / 7 = 14 rem 2; MTLO during busy must be dropped
        drive(3'd2, 32'd100, 32'd7);
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        drive(3'd5, 32'h1234, 32'd0);
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL lock_stall: got %b expected 1", stall_req); end
        cyc();
        start = 1'b0;
        checks++; if (lo !== 32'd9) begin errors++; $display("FAIL lock_mtlo_ignored: got %h expected %h", lo, 32'd9); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_busy: got %b expected 1", busy); end
        repeat (7) cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_busy_end: got %b expected 0", busy); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL lock_lo: got %h expected %h", lo, 32'd14); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL lock_hi: got %h expected %h", hi, 32'd2); end
        // MTHI while idle: visible next cycle, no busy, LO untouched
        drive(3'd4, 32'hABCD, 32'd0);
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b expected 0", stall_req); end
        cyc();
        start = 1'b0;
        checks++; if (hi !== 32'hABCD) begin errors++; $display("FAIL mthi_hi: got %h expected %h", hi, 32'hABCD); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL mthi_lo: got %h expected %h", lo, 32'd14); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
        // op 6 is a no-op
        drive(3'd6, 32'hFFFF, 32'hFFFF);
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL nop_stall: got %b expected 0", stall_req); end
        cyc();
        start = 1'b0;
        checks++; if (hi !== 32'hABCD || lo !== 32'd14 || busy !== 1'b0) begin errors++; $display("FAIL nop_state: got hi=%h lo=%h busy=%b expected hi=abcd lo=e busy=0", hi, lo, busy); end
    endtask

    task automatic test_back_to_back();
        drive(3'd0, 32'd3, 32'd4);
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        checks++; if (busy !== 1'b0 || lo !== 32'd12 || hi !== 32'd0) begin errors++; $display("FAIL b2b_first: got hi=%h lo=%h busy=%b expected hi=0 lo=c busy=0", hi, lo, busy); end
        drive(3'd0, 32'd5, 32'd6);
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL b2b_stall: got %b expected 1", stall_req); end
        cyc();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", busy); end
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL b2b_hold: got %h expected %h", lo, 32'd12); end
        repeat (5) cyc();
        checks++; if (busy !== 1'b0 || lo !== 32'd30 || hi !== 32'd0) begin errors++; $display("FAIL b2b_second: got hi=%h lo=%h busy=%b expected hi=0 lo=1e busy=0", hi, lo, busy); end
    endtask

    task automatic test_reset_mid();
        drive(3'd2, 32'd100, 32'd3);
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        checks++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async: got hi=%h lo=%h busy=%b expected hi=0 lo=0 busy=0", hi, lo, busy); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (12) cyc();
        checks++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_nocommit: got hi=%h lo=%h busy=%b expected hi=0 lo=0 busy=0", hi, lo, busy); end
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_multu();
        test_div();
        test_interlock();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
